// File: rtl/vector_store_memory_if.sv
// rtl/vector_store_memory_if.sv - store request / read-port bundle for vector_store_memory
//
// Purpose: groups the store handshake and the image read port.
// Ports (signals):
//   WE     store request valid          (master -> slave)
//   Ready  engine idle, accepts request (slave -> master)
//   Addr   base pixel address           (master -> slave)
//   WD     16 x 16-bit store vector     (master -> slave)
//   Done   one-cycle store-complete     (slave -> master)
//   Oob    sticky out-of-range flag     (slave -> master)
//   RAddr  read pixel address           (master -> slave)
//   RData  registered pixel             (slave -> master)
interface vector_store_memory_if #(
    parameter int PIX_SIZE = 8
);
    logic                  WE;
    logic                  Ready;
    logic [15:0]           Addr;
    logic [15:0][15:0]     WD;
    logic                  Done;
    logic                  Oob;
    logic [15:0]           RAddr;
    logic [PIX_SIZE-1:0]   RData;

    modport master (
        output WE, Addr, WD, RAddr,
        input  Ready, Done, Oob, RData
    );

    modport slave (
        input  WE, Addr, WD, RAddr,
        output Ready, Done, Oob, RData
    );
endinterface

// File: rtl/vector_store_memory.sv
// rtl/vector_store_memory.sv - saturating vector store engine over a byte image memory
//
// Purpose: accepts a store vector plus base address, saturates lanes 0..LANES-1
// to PIX_SIZE-bit pixels and writes them one per cycle; a registered read port
// dumps the image.
// Ports:
//   CLK  clock, rising edge
//   RST  synchronous active-low reset (FSM, Oob, RData; memory is never cleared)
//   bus  vector_store_memory_if.slave (WE/Ready/Addr/WD/Done/Oob/RAddr/RData)
module vector_store_memory #(
    parameter int IMAGE_WIDTH  = 96,
    parameter int IMAGE_HEIGHT = 96,
    parameter int PIX_SIZE     = 8,
    parameter int LANES        = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    vector_store_memory_if.slave bus
);
    localparam int DEPTH = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int AW    = $clog2(DEPTH);
    localparam int KW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [15:0] PIX_MAX = 16'((1 << PIX_SIZE) - 1);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t                         state;
    state_t                         state_next;
    logic [KW-1:0]                  k;
    logic [KW-1:0]                  k_next;
    logic [15:0]                    addr_reg;
    logic [LANES-1:0][PIX_SIZE-1:0] data_reg;
    logic [PIX_SIZE-1:0]            mem [DEPTH];
    logic [PIX_SIZE-1:0]            rdata;
    logic                           oob;
    logic [16:0]                    waddr;
    logic                           wr_in_range;
    logic                           wr_en;
    logic                           accept;
    logic                           last_lane;
    logic                           unused_lanes;

    function automatic logic [PIX_SIZE-1:0] saturate(input logic [15:0] v);
        return (v > PIX_MAX) ? PIX_MAX[PIX_SIZE-1:0] : v[PIX_SIZE-1:0];
    endfunction

    // 17-bit sum so a base near 0xFFFF lands out of range instead of wrapping to 0.
    assign waddr        = {1'b0, addr_reg} + 17'(k);
    assign wr_in_range  = waddr < 17'(DEPTH);
    assign last_lane    = (k == KW'(LANES - 1));
    assign unused_lanes = ^bus.WD[15:LANES];

    always_comb begin
        state_next = state;
        k_next     = k;
        bus.Ready  = 1'b0;
        bus.Done   = 1'b0;
        accept     = 1'b0;
        wr_en      = 1'b0;
        case (state)
            IDLE: begin
                bus.Ready = 1'b1;
                if (bus.WE) begin
                    accept     = 1'b1;
                    k_next     = '0;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                wr_en  = wr_in_range;
                k_next = k + 1'b1;
                if (last_lane) begin
                    k_next     = '0;
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.Done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= IDLE;
            k     <= '0;
            oob   <= 1'b0;
        end else begin
            state <= state_next;
            k     <= k_next;
            if (state == WRITE && !wr_in_range)
                oob <= 1'b1;
        end
    end

    // Saturate at capture so the write path only selects a stored pixel.
    always_ff @(posedge CLK) begin
        if (RST && accept) begin
            addr_reg <= bus.Addr;
            for (int i = 0; i < LANES; i++)
                data_reg[i] <= saturate(bus.WD[i]);
        end
    end

    // Write gated by RST so a reset edge mid-store writes nothing.
    always_ff @(posedge CLK) begin
        if (RST && wr_en)
            mem[waddr[AW-1:0]] <= data_reg[k];
    end

    // Non-blocking read of the same array gives read-before-write on collision.
    always_ff @(posedge CLK) begin
        if (!RST)
            rdata <= '0;
        else if (bus.RAddr < 16'(DEPTH))
            rdata <= mem[bus.RAddr[AW-1:0]];
        else
            rdata <= '0;
    end

    assign bus.Oob   = oob;
    assign bus.RData = rdata;
endmodule

// File: tb/tb_vector_store_memory.sv
// tb/tb_vector_store_memory.sv - randomized self-checking bench for vector_store_memory
module tb_vector_store_memory;
    localparam int DEPTH = 96 * 96;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [7:0] model_mem [DEPTH];
    logic       model_oob = 1'b0;

    vector_store_memory_if #(.PIX_SIZE(8)) bus ();

    vector_store_memory #(
        .IMAGE_WIDTH (96),
        .IMAGE_HEIGHT(96),
        .PIX_SIZE    (8),
        .LANES       (8)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] sat(input logic [15:0] v);
        return (v > 16'd255) ? 8'hFF : v[7:0];
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.Ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (bus.Ready !== 1'b1)
            check_eq("ready_timeout", 32'(bus.Ready), 32'd1);
    endtask

    task automatic model_store(input int addr, input logic [15:0][15:0] wd, input int nl);
        for (int i = 0; i < nl; i++) begin
            if (addr + i < DEPTH) model_mem[addr + i] = sat(wd[i]);
            else                  model_oob = 1'b1;
        end
    endtask

    task automatic read_check(input int a, input string tag);
        logic [7:0] exp;
        bus.RAddr = 16'(a);
        tick();
        exp = (a < DEPTH) ? model_mem[a] : 8'h00;
        check_eq($sformatf("%s[%0d]", tag, a), 32'(bus.RData), 32'(exp));
    endtask

    task automatic check_region(input int addr);
        for (int a = addr - 1; a <= addr + 8; a++)
            if (a >= 0 && a < DEPTH) read_check(a, "mem");
    endtask

    function automatic logic [15:0][15:0] rand_wd();
        logic [15:0][15:0] wd;
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 2))
                0:       wd[i] = 16'($urandom_range(0, 255));
                1:       wd[i] = 16'($urandom_range(256, 65535));
                default: wd[i] = ($urandom_range(0, 1) != 0) ? 16'd255 : 16'd256;
            endcase
        end
        return wd;
    endfunction

    // Full store with cycle-exact Ready/Done checks; coll>=0 reads lane coll's
    // address in the very cycle it is written, then the next cycle.
    task automatic run_store(input int addr, input logic [15:0][15:0] wd, input int coll);
        logic [7:0] oldv = 8'h00;
        logic [7:0] newv = 8'h00;
        wait_ready();
        bus.WE   = 1'b1;
        bus.Addr = 16'(addr);
        bus.WD   = wd;
        if (coll >= 0) begin
            oldv = model_mem[addr + coll];
            newv = sat(wd[coll]);
        end
        tick();
        bus.WE   = 1'b0;
        bus.Addr = 16'($urandom);
        bus.WD   = rand_wd();
        check_eq("acc_ready", 32'(bus.Ready), 32'd0);
        check_eq("acc_done", 32'(bus.Done), 32'd0);
        for (int c = 1; c <= 9; c++) begin
            if (coll >= 0 && c == 1 + coll) bus.RAddr = 16'(addr + coll);
            tick();
            check_eq($sformatf("busy_ready_c%0d", c), 32'(bus.Ready), 32'(c == 9));
            check_eq($sformatf("done_c%0d", c), 32'(bus.Done), 32'(c == 8));
            if (coll >= 0 && c == 1 + coll) check_eq("coll_old", 32'(bus.RData), 32'(oldv));
            if (coll >= 0 && c == 2 + coll) check_eq("coll_new", 32'(bus.RData), 32'(newv));
        end
        model_store(addr, wd, 8);
        check_eq("oob", 32'(bus.Oob), 32'(model_oob));
        check_region(addr);
    endtask

    initial begin
        logic [15:0][15:0] wd;
        logic [15:0][15:0] wa;
        logic [15:0][15:0] wb;
        logic [15:0][15:0] wc;
        int acc, dones, t_first, t_second;

        for (int a = 0; a < DEPTH; a++) model_mem[a] = 8'h00;
        bus.WE = 1'b0; bus.Addr = '0; bus.WD = '0; bus.RAddr = '0;

        // Reset
        RST = 1'b0;
        repeat (2) tick();
        check_eq("rst_ready", 32'(bus.Ready), 32'd1);
        check_eq("rst_done", 32'(bus.Done), 32'd0);
        check_eq("rst_oob", 32'(bus.Oob), 32'd0);
        check_eq("rst_rdata", 32'(bus.RData), 32'd0);
        RST = 1'b1;
        for (int a = 0; a < DEPTH; a++) read_check(a, "init");
        read_check(DEPTH, "raddr_oob");

        // Basic store
        for (int i = 0; i < 16; i++) wd[i] = 16'(i + 1);
        run_store(100, wd, -1);

        // Saturation boundaries
        wd = '0;
        wd[0] = 16'h00FF; wd[1] = 16'h0100; wd[2] = 16'hFFFF; wd[3] = 16'h0080;
        run_store(0, wd, 1);

        // Out of range tail, then Oob must stay set through an in-range store
        for (int i = 0; i < 16; i++) wd[i] = 16'(16'h11 + i);
        run_store(9212, wd, 2);
        check_eq("oob_set", 32'(bus.Oob), 32'd1);
        run_store(104, rand_wd(), 3);
        check_eq("oob_sticky", 32'(bus.Oob), 32'd1);

        // Handshake: WE held high across two stores, plus a mid-WRITE pulse
        wa = rand_wd(); wb = rand_wd(); wc = rand_wd();
        acc = 0; dones = 0; t_first = -1; t_second = -1;
        wait_ready();
        bus.WE = 1'b1; bus.Addr = 16'd1000; bus.WD = wa;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (bus.Ready === 1'b1 && bus.WE === 1'b1) begin
                acc++;
                if (acc == 1) t_first = cyc;
                else if (acc == 2) t_second = cyc;
            end
            tick();
            if (bus.Done === 1'b1) dones++;
            if (acc == 1 && cyc == t_first) begin bus.Addr = 16'd1100; bus.WD = wb; end
            if (acc >= 2 && cyc == t_second) bus.WE = 1'b0;
            if (acc >= 2 && cyc == t_second + 3) begin bus.WE = 1'b1; bus.Addr = 16'd1200; bus.WD = wc; end
            if (acc >= 2 && cyc == t_second + 4) bus.WE = 1'b0;
        end
        bus.WE = 1'b0;
        check_eq("hs_accepts", 32'(acc), 32'd2);
        check_eq("hs_gap", 32'(t_second - t_first), 32'd10);
        check_eq("hs_dones", 32'(dones), 32'd2);
        model_store(1000, wa, 8);
        model_store(1100, wb, 8);
        check_region(1000);
        check_region(1100);
        check_region(1200);

        // Randomized stores
        for (int n = 0; n < 24; n++) begin
            int addr, coll, r;
            r = $urandom_range(0, 9);
            if (r <= 5)      addr = $urandom_range(0, 400);
            else if (r <= 7) addr = $urandom_range(9200, DEPTH - 1);
            else if (r == 8) addr = $urandom_range(0, DEPTH - 1);
            else             addr = $urandom_range(65528, 65535);
            coll = $urandom_range(0, 7);
            if (addr + coll >= DEPTH) coll = -1;
            run_store(addr, rand_wd(), coll);
        end

        // Reset after lane 2 is written
        check_eq("pre_rst_oob", 32'(bus.Oob), 32'd1);
        wd = rand_wd();
        wait_ready();
        bus.WE = 1'b1; bus.Addr = 16'd5000; bus.WD = wd;
        tick();
        bus.WE = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            check_eq("mid_done", 32'(bus.Done), 32'd0);
        end
        RST = 1'b0;
        tick();
        check_eq("mid_rst_ready", 32'(bus.Ready), 32'd1);
        check_eq("mid_rst_done", 32'(bus.Done), 32'd0);
        check_eq("mid_rst_oob", 32'(bus.Oob), 32'd0);
        check_eq("mid_rst_rdata", 32'(bus.RData), 32'd0);
        RST = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            check_eq("post_rst_done", 32'(bus.Done), 32'd0);
            check_eq("post_rst_ready", 32'(bus.Ready), 32'd1);
        end
        model_store(5000, wd, 3);
        model_oob = 1'b0;
        check_region(5000);

        // Final image dump
        for (int a = 0; a < DEPTH; a++) read_check(a, "dump");
        read_check(DEPTH, "raddr_oob");
        read_check(40000, "raddr_oob");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
